// File: rtl/histogram_pkg.sv
// rtl/histogram_pkg.sv - shared widths, FSM states and saturating add for the histogram accumulator
package histogram_pkg;

  localparam int DEF_BIN_W = 10;
  localparam int DEF_CNT_W = 32;

  typedef enum logic [2:0] {
    INIT,
    ACCUM,
    FL_RD,
    FL_WR,
    RO_RD,
    RO_CAP,
    RO_OUT
  } hist_state_t;

  // Adds two w-bit counts (w <= 32) and clamps at 2^w-1; the 64-bit operands keep the carry.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b, input int w);
    logic [63:0] sum;
    logic [63:0] max;
    sum = a + b;
    max = (64'd1 << w) - 64'd1;
    return (sum > max) ? max : sum;
  endfunction

endpackage

// File: rtl/hist_run_coalescer.sv
// rtl/hist_run_coalescer.sv - run-length coalescing of identical consecutive pixels
module hist_run_coalescer
  import histogram_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_accept,
  input  logic [BIN_W-1:0] i_pixel,
  input  logic             i_flush_wr,
  output logic             o_run_valid,
  output logic [BIN_W-1:0] o_run_bin,
  output logic [CNT_W-1:0] o_run_cnt,
  output logic             o_pend_valid,
  output logic             o_flush_req
);

  logic             r_run_valid;
  logic [BIN_W-1:0] r_run_bin;
  logic [CNT_W-1:0] r_run_cnt;
  logic             r_pend_valid;
  logic [BIN_W-1:0] r_pend_bin;
  logic             w_cnt_max;

  assign w_cnt_max    = (r_run_cnt == {CNT_W{1'b1}});
  // A new pixel ends the current run if it differs or the run count cannot grow further.
  assign o_flush_req  = i_accept && r_run_valid && ((i_pixel != r_run_bin) || w_cnt_max);
  assign o_run_valid  = r_run_valid;
  assign o_run_bin    = r_run_bin;
  assign o_run_cnt    = r_run_cnt;
  assign o_pend_valid = r_pend_valid;

  // Track the open run; a flush write promotes the pending pixel to a fresh run of one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_run_valid  <= 1'b0;
      r_run_bin    <= '0;
      r_run_cnt    <= '0;
      r_pend_valid <= 1'b0;
      r_pend_bin   <= '0;
    end else if (i_flush_wr) begin
      if (r_pend_valid) begin
        r_run_bin    <= r_pend_bin;
        r_run_cnt    <= CNT_W'(1);
        r_pend_valid <= 1'b0;
      end else begin
        r_run_valid <= 1'b0;
      end
    end else if (i_accept) begin
      if (!r_run_valid) begin
        r_run_valid <= 1'b1;
        r_run_bin   <= i_pixel;
        r_run_cnt   <= CNT_W'(1);
      end else if (o_flush_req) begin
        r_pend_bin   <= i_pixel;
        r_pend_valid <= 1'b1;
      end else begin
        r_run_cnt <= r_run_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/histogram_accumulator.sv
// rtl/histogram_accumulator.sv - histogram RAM read-modify-write controller; HIST_PIXCOUNT_EN adds pixel_count_o
module histogram_accumulator
  import histogram_pkg::*;
#(
  parameter int BIN_W = DEF_BIN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pixel_valid_i,
  input  logic [BIN_W-1:0] pixel_i,
  output logic             pixel_ready_o,
  input  logic             frame_end_i,
  output logic             hist_valid_o,
  input  logic             hist_ready_i,
  output logic [BIN_W-1:0] hist_bin_o,
  output logic [CNT_W-1:0] hist_data_o,
  output logic             frame_done_o,
  output logic             init_done_o,
  output logic [BIN_W-1:0] ram_addr_o,
  output logic             ram_we_o,
  output logic [CNT_W-1:0] ram_data_o,
  input  logic [CNT_W-1:0] ram_q_i
`ifdef HIST_PIXCOUNT_EN
  ,
  output logic [31:0]      pixel_count_o
`endif
);

  hist_state_t      r_state;
  logic [BIN_W-1:0] r_bin;
  logic             r_fe;
  logic             r_init_done;
  logic             r_hist_valid;
  logic [BIN_W-1:0] r_hist_bin;
  logic [CNT_W-1:0] r_hist_data;
  logic             r_frame_done;

  logic             w_accept;
  logic             w_run_valid;
  logic [BIN_W-1:0] w_run_bin;
  logic [CNT_W-1:0] w_run_cnt;
  logic             w_pend_valid;
  logic             w_flush_req;
  logic             w_bin_last;
  logic [CNT_W-1:0] w_sat_sum;
  logic [BIN_W-1:0] w_ram_addr;
  logic             w_ram_we;
  logic [CNT_W-1:0] w_ram_data;

  assign w_accept   = (r_state == ACCUM) && pixel_valid_i;
  assign w_bin_last = (r_bin == {BIN_W{1'b1}});
  assign w_sat_sum  = CNT_W'(sat_add(64'(ram_q_i), 64'(w_run_cnt), CNT_W));

  hist_run_coalescer #(
    .BIN_W(BIN_W),
    .CNT_W(CNT_W)
  ) u_coalescer (
    .clk         (clk),
    .reset       (reset),
    .i_accept    (w_accept),
    .i_pixel     (pixel_i),
    .i_flush_wr  (r_state == FL_WR),
    .o_run_valid (w_run_valid),
    .o_run_bin   (w_run_bin),
    .o_run_cnt   (w_run_cnt),
    .o_pend_valid(w_pend_valid),
    .o_flush_req (w_flush_req)
  );

  // Main sequencer: clear RAM, accumulate runs, then read out and clear every bin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= INIT;
      r_bin        <= '0;
      r_fe         <= 1'b0;
      r_init_done  <= 1'b0;
      r_hist_valid <= 1'b0;
      r_hist_bin   <= '0;
      r_hist_data  <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        INIT: begin
          r_bin <= r_bin + BIN_W'(1);
          if (w_bin_last) begin
            r_state     <= ACCUM;
            r_init_done <= 1'b1;
          end
        end
        ACCUM: begin
          if (frame_end_i) begin
            r_fe    <= 1'b1;
            r_bin   <= '0;
            r_state <= (w_run_valid || w_accept) ? FL_RD : RO_RD;
          end else if (w_flush_req) begin
            r_state <= FL_RD;
          end
        end
        FL_RD: r_state <= FL_WR;
        FL_WR: begin
          // A run promoted from the pending slot at frame end still has to be flushed.
          if (r_fe && w_pend_valid) r_state <= FL_RD;
          else if (r_fe)            r_state <= RO_RD;
          else                      r_state <= ACCUM;
        end
        RO_RD: r_state <= RO_CAP;
        RO_CAP: begin
          r_hist_data  <= ram_q_i;
          r_hist_bin   <= r_bin;
          r_hist_valid <= 1'b1;
          r_state      <= RO_OUT;
        end
        RO_OUT: begin
          if (hist_ready_i) begin
            r_hist_valid <= 1'b0;
            r_bin        <= r_bin + BIN_W'(1);
            if (w_bin_last) begin
              r_frame_done <= 1'b1;
              r_fe         <= 1'b0;
              r_state      <= ACCUM;
            end else begin
              r_state <= RO_RD;
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  // RAM port mux: one access per cycle, a write only where a value must be stored.
  always_comb begin
    w_ram_addr = w_run_bin;
    w_ram_we   = 1'b0;
    w_ram_data = '0;
    case (r_state)
      INIT: begin
        w_ram_addr = r_bin;
        w_ram_we   = 1'b1;
      end
      FL_WR: begin
        w_ram_we   = 1'b1;
        w_ram_data = w_sat_sum;
      end
      RO_RD, RO_CAP: w_ram_addr = r_bin;
      RO_OUT: begin
        w_ram_addr = r_bin;
        w_ram_we   = r_hist_valid && hist_ready_i;
      end
      default: w_ram_addr = w_run_bin;
    endcase
  end

  assign ram_addr_o    = w_ram_addr;
  assign ram_we_o      = w_ram_we & ~reset;
  assign ram_data_o    = w_ram_data;
  assign pixel_ready_o = (r_state == ACCUM);
  assign hist_valid_o  = r_hist_valid;
  assign hist_bin_o    = r_hist_bin;
  assign hist_data_o   = r_hist_data;
  assign frame_done_o  = r_frame_done;
  assign init_done_o   = r_init_done;

`ifdef HIST_PIXCOUNT_EN
  logic [31:0] r_pix_cnt;
  logic [31:0] r_pix_latch;
  logic [31:0] w_pix_next;

  assign w_pix_next = w_accept ? 32'(sat_add(64'(r_pix_cnt), 64'd1, 32)) : r_pix_cnt;

  // Count accepted pixels; frame end snapshots the count including a same-cycle pixel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pix_cnt   <= '0;
      r_pix_latch <= '0;
    end else if ((r_state == ACCUM) && frame_end_i) begin
      r_pix_latch <= w_pix_next;
      r_pix_cnt   <= '0;
    end else begin
      r_pix_cnt <= w_pix_next;
    end
  end

  assign pixel_count_o = r_pix_latch;
`endif

endmodule

// File: tb/tb_histogram_accumulator.sv
// tb/tb_histogram_accumulator.sv - self-checking bench for histogram_accumulator
`timescale 1ns/1ps
module tb_histogram_accumulator;

  localparam int BW  = 10;
  localparam int CW  = 32;
  localparam int NB  = 1 << BW;
  localparam int BW2 = 4;
  localparam int CW2 = 4;
  localparam int NB2 = 1 << BW2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          pixel_valid_i = 1'b0;
  logic [BW-1:0] pixel_i = '0;
  logic          pixel_ready_o;
  logic          frame_end_i = 1'b0;
  logic          hist_valid_o;
  logic          hist_ready_i = 1'b0;
  logic [BW-1:0] hist_bin_o;
  logic [CW-1:0] hist_data_o;
  logic          frame_done_o;
  logic          init_done_o;
  logic [BW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [CW-1:0] ram_data_o;
  logic [CW-1:0] ram_q_i;
`ifdef HIST_PIXCOUNT_EN
  logic [31:0]   pixel_count_o;
  logic [31:0]   pixel_count_o2;
`endif

  logic           pv2 = 1'b0;
  logic [BW2-1:0] px2 = '0;
  logic           pixel_ready_o2;
  logic           fe2 = 1'b0;
  logic           hist_valid_o2;
  logic           hr2 = 1'b0;
  logic [BW2-1:0] hist_bin_o2;
  logic [CW2-1:0] hist_data_o2;
  logic           frame_done_o2;
  logic           init_done_o2;
  logic [BW2-1:0] ram_addr_o2;
  logic           ram_we_o2;
  logic [CW2-1:0] ram_data_o2;
  logic [CW2-1:0] ram_q_i2;

  histogram_accumulator #(.BIN_W(BW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pixel_valid_i(pixel_valid_i), .pixel_i(pixel_i),
    .pixel_ready_o(pixel_ready_o), .frame_end_i(frame_end_i), .hist_valid_o(hist_valid_o),
    .hist_ready_i(hist_ready_i), .hist_bin_o(hist_bin_o), .hist_data_o(hist_data_o),
    .frame_done_o(frame_done_o), .init_done_o(init_done_o), .ram_addr_o(ram_addr_o),
    .ram_we_o(ram_we_o), .ram_data_o(ram_data_o), .ram_q_i(ram_q_i)
`ifdef HIST_PIXCOUNT_EN
    , .pixel_count_o(pixel_count_o)
`endif
  );

  histogram_accumulator #(.BIN_W(BW2), .CNT_W(CW2)) dut2 (
    .clk(clk), .reset(reset), .pixel_valid_i(pv2), .pixel_i(px2),
    .pixel_ready_o(pixel_ready_o2), .frame_end_i(fe2), .hist_valid_o(hist_valid_o2),
    .hist_ready_i(hr2), .hist_bin_o(hist_bin_o2), .hist_data_o(hist_data_o2),
    .frame_done_o(frame_done_o2), .init_done_o(init_done_o2), .ram_addr_o(ram_addr_o2),
    .ram_we_o(ram_we_o2), .ram_data_o(ram_data_o2), .ram_q_i(ram_q_i2)
`ifdef HIST_PIXCOUNT_EN
    , .pixel_count_o(pixel_count_o2)
`endif
  );

  logic [CW-1:0]  mem  [NB];
  logic [CW2-1:0] mem2 [NB2];

  always @(posedge clk) begin
    if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
    ram_q_i <= mem[ram_addr_o];
    if (ram_we_o2) mem2[ram_addr_o2] <= ram_data_o2;
    ram_q_i2 <= mem2[ram_addr_o2];
  end

  int checks = 0;
  int passed = 0;
  int tmo = 0;
  int fd_cnt = 0;
  int fd_cnt2 = 0;
  int ref_h [NB];
  int ref_pix = 0;
  int got_h [NB];

  always @(negedge clk) begin
    if (frame_done_o)  fd_cnt++;
    if (frame_done_o2) fd_cnt2++;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic clear_ref();
    for (int i = 0; i < NB; i++) ref_h[i] = 0;
    ref_pix = 0;
  endtask

  task automatic do_reset_and_init();
    int werr;
    werr = 0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < NB; i++) begin
      if (ram_we_o !== 1'b1 || ram_addr_o !== BW'(i) || ram_data_o !== '0) werr++;
      @(negedge clk);
    end
    check("init_write_errors", werr, 0);
    check("init_done", longint'(init_done_o), 1);
    check("pixel_ready_after_init", longint'(pixel_ready_o), 1);
    check("ram_we_idle_after_init", longint'(ram_we_o), 0);
    clear_ref();
  endtask

  task automatic send(input logic pv, input logic [BW-1:0] p, input logic fe);
    int t;
    t = 0;
    pixel_valid_i = pv;
    pixel_i = p;
    frame_end_i = fe;
    while (pixel_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) tmo++;
    @(negedge clk);
    if (pv) begin
      ref_h[p]++;
      ref_pix++;
    end
    pixel_valid_i = 1'b0;
    frame_end_i = 1'b0;
  endtask

  task automatic readout(input bit rnd, output int bin_err, output int data_err, output int stab_err);
    int t;
    bit r;
    logic [BW-1:0] b0;
    logic [CW-1:0] d0;
    bin_err = 0;
    data_err = 0;
    stab_err = 0;
    for (int b = 0; b < NB; b++) begin
      t = 0;
      while (hist_valid_o !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) begin
        tmo++;
        return;
      end
      b0 = hist_bin_o;
      d0 = hist_data_o;
      got_h[b] = int'(d0);
      if (b0 !== BW'(b)) bin_err++;
      if (d0 !== CW'(ref_h[b])) data_err++;
      do begin
        r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        hist_ready_i = r;
        @(negedge clk);
        if (!r && (hist_valid_o !== 1'b1 || hist_bin_o !== b0 || hist_data_o !== d0)) stab_err++;
      end while (!r);
      hist_ready_i = 1'b0;
    end
  endtask

  task automatic frame_readout(input string tag, input bit rnd);
    int be, de, se, fd0, nz;
    fd0 = fd_cnt;
    readout(rnd, be, de, se);
    check({tag, "_bin_order_err"}, be, 0);
    check({tag, "_data_vs_model_err"}, de, 0);
    check({tag, "_stall_stability_err"}, se, 0);
    repeat (2) @(negedge clk);
    check({tag, "_frame_done_pulses"}, fd_cnt - fd0, 1);
    check({tag, "_ready_after_readout"}, longint'(pixel_ready_o), 1);
`ifdef HIST_PIXCOUNT_EN
    check({tag, "_pixel_count"}, longint'(pixel_count_o), ref_pix);
`endif
    nz = 0;
    for (int i = 0; i < NB; i++) if (mem[i] !== '0) nz++;
    check({tag, "_ram_cleared_nonzero"}, nz, 0);
    clear_ref();
  endtask

  typedef struct {
    int n;
    int px [6];
    bit fe_same;
    int exp_bin [3];
    int exp_cnt [3];
  } vec_t;

  vec_t tv [5];

  initial begin
    int n, t, prev, nz2, rnd_n;
    int pool [4];
    int exp3;

    tv[0] = '{4, '{5, 5, 5, 7, 0, 0},       1'b0, '{5, 7, 0},    '{3, 1, 0}};
    tv[1] = '{1, '{9, 0, 0, 0, 0, 0},       1'b1, '{9, 0, 0},    '{1, 0, 0}};
    tv[2] = '{0, '{0, 0, 0, 0, 0, 0},       1'b0, '{0, 0, 0},    '{0, 0, 0}};
    tv[3] = '{5, '{2, 4, 2, 2, 1023, 0},    1'b1, '{2, 4, 1023}, '{3, 1, 1}};
    tv[4] = '{6, '{0, 0, 8, 8, 8, 0},       1'b1, '{0, 8, 0},    '{3, 3, 0}};

    #2;
    check("rst_pixel_ready", longint'(pixel_ready_o), 0);
    check("rst_hist_valid", longint'(hist_valid_o), 0);
    check("rst_init_done", longint'(init_done_o), 0);
    check("rst_ram_we", longint'(ram_we_o), 0);
    check("rst_frame_done", longint'(frame_done_o), 0);
    @(negedge clk);
    do_reset_and_init();

    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < tv[i].n; k++)
        send(1'b1, BW'(tv[i].px[k]), tv[i].fe_same && (k == tv[i].n - 1));
      if (!(tv[i].fe_same && tv[i].n > 0)) send(1'b0, '0, 1'b1);
      frame_readout($sformatf("vec%0d", i), (i % 2) == 1);
      for (int k = 0; k < 3; k++)
        if (tv[i].exp_cnt[k] != 0)
          check($sformatf("vec%0d_bin%0d", i, tv[i].exp_bin[k]), got_h[tv[i].exp_bin[k]], tv[i].exp_cnt[k]);
    end

    for (int f = 0; f < 2; f++) begin
      for (int j = 0; j < 4; j++) pool[j] = $urandom_range(0, NB - 1);
      prev = pool[0];
      rnd_n = $urandom_range(30, 60);
      for (int k = 0; k < rnd_n; k++) begin
        if ($urandom_range(0, 9) > 5) prev = pool[$urandom_range(0, 3)];
        repeat ($urandom_range(0, 2)) @(negedge clk);
        send(1'b1, BW'(prev), (k == rnd_n - 1) && f == 1);
      end
      if (f == 0) send(1'b0, '0, 1'b1);
      frame_readout($sformatf("rand%0d", f), 1'b1);
    end

    send(1'b1, BW'(700), 1'b0);
    send(1'b1, BW'(700), 1'b0);
    send(1'b1, BW'(300), 1'b0);
    send(1'b1, BW'(5), 1'b1);
    hist_ready_i = 1'b1;
    t = 0;
    while (!(hist_valid_o === 1'b1 && hist_bin_o === BW'(300)) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) tmo++;
    reset = 1'b1;
    hist_ready_i = 1'b0;
    #1;
    check("midro_rst_hist_valid", longint'(hist_valid_o), 0);
    check("midro_rst_hist_data", longint'(hist_data_o), 0);
    check("midro_rst_hist_bin", longint'(hist_bin_o), 0);
    check("midro_rst_ram_we", longint'(ram_we_o), 0);
    check("midro_rst_init_done", longint'(init_done_o), 0);
    check("midro_rst_pixel_ready", longint'(pixel_ready_o), 0);
    @(negedge clk);
    do_reset_and_init();
    send(1'b1, BW'(5), 1'b1);
    frame_readout("after_reset", 1'b0);
    check("after_reset_bin5", got_h[5], 1);
    check("after_reset_bin700", got_h[700], 0);

    repeat (20) @(negedge clk);
    check("dut2_init_done", longint'(init_done_o2), 1);
    pv2 = 1'b1;
    px2 = BW2'(3);
    n = 0;
    t = 0;
    while (n < 20 && t < 300) begin
      if (pixel_ready_o2) n++;
      @(negedge clk);
      t++;
    end
    pv2 = 1'b0;
    if (t >= 300) tmo++;
    repeat (4) @(negedge clk);
    check("dut2_first_sat_flush", longint'(mem2[3]), (1 << CW2) - 1);
    fe2 = 1'b1;
    t = 0;
    while (pixel_ready_o2 !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    fe2 = 1'b0;
    exp3 = (20 < (1 << CW2) - 1) ? 20 : (1 << CW2) - 1;
    hr2 = 1'b1;
    nz2 = 0;
    for (int b = 0; b < NB2; b++) begin
      t = 0;
      while (hist_valid_o2 !== 1'b1 && t < 20) begin
        @(negedge clk);
        t++;
      end
      if (t >= 20) tmo++;
      if (b == 3) check("dut2_bin3_saturated", longint'(hist_data_o2), exp3);
      else if (hist_data_o2 !== '0 || hist_bin_o2 !== BW2'(b)) nz2++;
      @(negedge clk);
    end
    hr2 = 1'b0;
    repeat (2) @(negedge clk);
    check("dut2_other_bins_err", nz2, 0);
    check("dut2_frame_done_pulses", fd_cnt2, 1);
`ifdef HIST_PIXCOUNT_EN
    check("dut2_pixel_count", longint'(pixel_count_o2), 20);
`endif

    check("timeouts", tmo, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
